muldiv_sequencer: RTL and testbench

Iterative multiply/divide unit with its own sequencing FSM, attached to the execute stage of the 5-stage pipeline. It accepts one MULT/MULTU/DIV/DIVU operation, runs a WIDTH-cycle shift-add or restoring-divide loop, and holds the pipeline stalled until the result is ready. It then writes the HI/LO registers and signals completion. It also honours the execute-stage flush from branch resolution.

---
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the execute stage.
// It runs one MULT/MULTU/DIV/DIVU operation over WIDTH cycles, stalls the
// front of the pipeline while it works, then commits the result to HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_is_div;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_dbz;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_is_dbz;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_mul_add;
  logic [WIDTH:0]   w_mul_sum;
  logic [AW-1:0]    w_mul_acc;
  logic [CW-1:0]    w_div_idx;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [AW-1:0]    w_div_acc;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // Issue decode: signed ops (op[0]=1) work on magnitudes plus sign flags
  assign w_accept = (r_state == S_IDLE) & start & ~flush;
  assign w_is_dbz = op[1] & (src_b == '0);
  assign w_neg_a  = op[0] & src_a[WIDTH-1];
  assign w_neg_b  = op[0] & src_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -src_a : src_a;
  assign w_mag_b  = w_neg_b ? -src_b : src_b;

  // Shift-add step: multiplier bit count selects the add, then shift right
  assign w_mul_add = r_b[r_count] ? r_a : '0;
  assign w_mul_sum = {1'b0, r_acc[AW-1:WIDTH]} + {1'b0, w_mul_add};
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: dividend bits enter MSB first; remainder needs one spare bit
  assign w_div_idx = CW'(WIDTH - 1) - r_count;
  assign w_rem_sh  = {r_acc[AW-1:WIDTH], r_a[w_div_idx]};
  assign w_rem_ge  = w_rem_sh >= {1'b0, r_b};
  assign w_rem_sub = WIDTH'(w_rem_sh - {1'b0, r_b});
  assign w_div_acc = w_rem_ge ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                              : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // Sign correction applied in FIX; results wrap mod 2^WIDTH
  always_comb begin
    w_fix_hi = r_acc[AW-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_dbz) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
    end else if (!r_is_div) begin
      if (r_sign_a ^ r_sign_b) {w_fix_hi, w_fix_lo} = -r_acc;
    end else begin
      if (r_sign_a ^ r_sign_b) w_fix_lo = -r_acc[WIDTH-1:0];
      if (r_sign_a)            w_fix_hi = -r_acc[AW-1:WIDTH];
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_dbz ? S_FIX : S_RUN;
      S_RUN: begin
        if (flush)                            w_state_nxt = S_IDLE;
        else if (r_count == CW'(WIDTH - 1))   w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy        <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FIX);
      r_done        <= (w_state_nxt == S_DONE);
      r_div_by_zero <= (w_state_nxt == S_DONE) && r_dbz;
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dbz    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_is_div <= op[1];
      r_sign_a <= w_neg_a;
      r_sign_b <= w_neg_b;
      r_dbz    <= w_is_dbz;
      r_a      <= w_is_dbz ? src_a : w_mag_a;
      r_b      <= w_mag_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= r_is_div ? w_div_acc : w_mul_acc;
      r_count  <= r_count + CW'(1);
    end
  end

  // HI/LO commit on the FIX->DONE edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == S_FIX) && (w_state_nxt == S_DONE)) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end
  end

  assign stall       = w_accept | (r_state == S_RUN) | (r_state == S_FIX);
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         flush = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         stall, busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
    .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (rst_n && div_by_zero) begin
      chk("dbz_without_done", 32'(div_by_zero), 32'(0));
    end
  end

  // Issue one op, push its expectation, wait for done and check stall length
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic ed, input int lat);
    int  scnt;
    bit  seen;
    @(posedge clk); #1;
    op = o; src_a = a; src_b = b; start = 1'b1;
    sb_q.push_back('{hi: eh, lo: el, dbz: ed, cyc: cyc + lat});
    scnt = 0;
    seen = 1'b0;
    @(negedge clk);
    if (stall) scnt++;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall) scnt++;
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
    chk("stall_cycles", 32'(scnt), 32'(lat));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations with hand-computed results
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    do_op(2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
    do_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
    do_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34);
    do_op(2'b10, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 2);
    do_op(2'b11, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1, 2);
    do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
    do_op(2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
    do_op(2'b00, 32'h80000001, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0, 34);

    // Flush in RUN at count 10: no done, HI/LO kept
    @(posedge clk); #1;
    op = 2'b00; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", 32'(busy), 32'(1));
    chk("flush_stall_before", 32'(stall), 32'(1));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", 32'(busy), 32'(0));
    chk("flush_stall_after", 32'(stall), 32'(0));
    chk("flush_hi", hi, 32'h11111111);
    chk("flush_lo", lo, 32'h22222222);
    repeat (40) @(negedge clk);
    chk("flush_hi_later", hi, 32'h11111111);
    do_op(2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34);

    // Asynchronous reset in RUN at count 20
    @(posedge clk); #1;
    op = 2'b00; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_stall", 32'(stall), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_stall", 32'(stall), 32'(0));
    chk("post_rst_busy", 32'(busy), 32'(0));

    // Start together with flush in IDLE is ignored
    @(posedge clk); #1;
    op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("start_flush_stall", 32'(stall), 32'(0));
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_flush_busy", 32'(busy), 32'(0));
    chk("start_flush_lo", lo, 32'h0);

    // Normal operation after all of the above
    do_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
